rsa_engine_arbiter: RTL and testbench

- Shares one modular-exponentiation engine (x = exponent, y = base, z = result, start/done) between two requesters.
- Channel 0 is the encrypt requester and uses public exponent E. Channel 1 is the decrypt requester and uses private exponent D.
- Round-robin grant, valid/ready request and response handshakes, and per-channel result routing.
- Sits between the host-side encrypt/decrypt front ends and the single engine instance.

---
 rtl/rsa_engine_arbiter_if.sv | 49 ++++
 rtl/rsa_engine_arbiter.sv | 148 ++++++++++++++
 tb/tb_rsa_engine_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_engine_arbiter_if.sv
// ---------------------------------------------------------------------------
// rsa_engine_arbiter_if
// Bundles the two-channel request/response handshakes from the host-side
// encrypt/decrypt front ends together with the start/done interface of the
// shared modular-exponentiation engine.
//
// Signals:
//   req_valid[1:0]  request valid per channel (bit0 = enc, bit1 = dec)
//   req_ready[1:0]  request accept per channel, one-hot or zero
//   req_data0/1     channel operands (K bits)
//   rsp_valid[1:0]  result valid per channel, one-hot or zero
//   rsp_ready[1:0]  result accept per channel
//   rsp_data        shared result bus, rsp_err flags an out-of-range operand
//   eng_start       one-cycle engine start pulse
//   eng_x / eng_y   exponent / base presented to the engine
//   eng_z           engine result
//   eng_done        engine done level (a new completion is a rising edge)
//
// Modports:
//   slave  - the arbiter
//   master - the environment (host front ends plus the engine itself)
// ---------------------------------------------------------------------------
interface rsa_engine_arbiter_if #(
  parameter int K = 12
);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [K-1:0] req_data0;
  logic [K-1:0] req_data1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [K-1:0] rsp_data;
  logic         rsp_err;
  logic         eng_start;
  logic [K-1:0] eng_x;
  logic [K-1:0] eng_y;
  logic [K-1:0] eng_z;
  logic         eng_done;

  modport slave (
    input  req_valid, req_data0, req_data1, rsp_ready, eng_z, eng_done,
    output req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_x, eng_y
  );

  modport master (
    output req_valid, req_data0, req_data1, rsp_ready, eng_z, eng_done,
    input  req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_x, eng_y
  );
endinterface

// File: rtl/rsa_engine_arbiter.sv
// ---------------------------------------------------------------------------
// rsa_engine_arbiter
// Shares one modular-exponentiation engine between an encrypt requester
// (channel 0, public exponent E) and a decrypt requester (channel 1, private
// exponent D). Round-robin grant on contention, one request in flight at a
// time, result routed back to the channel that issued it. Operands >= N are
// answered immediately with rsp_err = 1 and never reach the engine.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    request/response handshakes and engine interface (slave side)
//   busy   high whenever the arbiter is not IDLE
// ---------------------------------------------------------------------------
module rsa_engine_arbiter #(
  parameter int K = 12,
  parameter int N = 3551,
  parameter int E = 5,
  parameter int D = 1373
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rsa_engine_arbiter_if.slave  bus,
  output logic                 busy
);

  localparam logic [K-1:0] MODULUS = K'(N);
  localparam logic [K-1:0] EXP_ENC = K'(E);
  localparam logic [K-1:0] EXP_DEC = K'(D);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [K-1:0] op_q, op_d;          // latched operand, drives eng_y
  logic [K-1:0] exp_q, exp_d;        // latched exponent, drives eng_x
  logic         cur_ch_q, cur_ch_d;
  logic         last_grant_q, last_grant_d;
  logic         done_q;
  logic [K-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_err_q, rsp_err_d;

  logic         grant_ch;
  logic [K-1:0] grant_op;

  // With both channels requesting, the one not served last time wins;
  // otherwise the sole requester wins.
  assign grant_ch = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
  assign grant_op = grant_ch ? bus.req_data1 : bus.req_data0;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave it unassigned and infer a latch.
    state_d       = state_q;
    op_d          = op_q;
    exp_d         = exp_q;
    cur_ch_d      = cur_ch_q;
    last_grant_d  = last_grant_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    bus.eng_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          // Handshake completes this cycle: ready is raised only for the
          // granted channel whose valid is already high.
          bus.req_ready = grant_ch ? 2'b10 : 2'b01;
          op_d          = grant_op;
          exp_d         = grant_ch ? EXP_DEC : EXP_ENC;
          cur_ch_d      = grant_ch;
          last_grant_d  = grant_ch;
          if (grant_op >= MODULUS) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        bus.eng_start = 1'b1;
        state_d       = WAIT;
      end

      WAIT: begin
        // Only a fresh rising edge counts; a done level still high from the
        // previous operation must not complete this one.
        if (bus.eng_done && !done_q) begin
          rsp_data_d = bus.eng_z;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end

      RESP: begin
        bus.rsp_valid = cur_ch_q ? 2'b10 : 2'b01;
        if (bus.rsp_ready[cur_ch_q]) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state is reset, including the datapath registers, because the
  // engine operands and the result bus are visible outputs with defined
  // reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      exp_q        <= '0;
      cur_ch_q     <= 1'b0;
      last_grant_q <= 1'b1;
      done_q       <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      op_q         <= op_d;
      exp_q        <= exp_d;
      cur_ch_q     <= cur_ch_d;
      last_grant_q <= last_grant_d;
      done_q       <= bus.eng_done;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.eng_x    = exp_q;
  assign bus.eng_y    = op_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rsa_engine_arbiter
// Directed bench for rsa_engine_arbiter. A behavioural engine answers
// eng_start after a fixed latency; a scoreboard gets the expected response
// when a request handshake is seen and is popped when the response
// handshake completes. Inputs change #1 after the rising edge; outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_rsa_engine_arbiter;
  localparam int K = 12;
  localparam int N = 3551;
  localparam int E = 5;
  localparam int D = 1373;
  localparam int L = 20;   // engine latency, start edge to done rise

  typedef struct packed {
    logic         ch;
    logic         err;
    logic [K-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  rsa_engine_arbiter_if #(.K(K)) bus ();

  rsa_engine_arbiter #(.K(K), .N(N), .E(E), .D(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [K-1:0] modexp(input logic [K-1:0] b, input logic [K-1:0] e);
    longint r = 1;
    longint x = longint'(b) % N;
    for (int i = K - 1; i >= 0; i--) begin
      r = (r * r) % N;
      if (e[i]) r = (r * x) % N;
    end
    return r[K-1:0];
  endfunction

  // ---------------- behavioural engine ----------------
  logic         eng_done_r = 1'b0;
  logic [K-1:0] eng_z_r = '0;
  logic [K-1:0] eng_res = '0;
  int           eng_cnt = 0;
  int           eng_hc = 0;
  int           hold_h = 0;   // cycles done stays high after a start

  assign bus.eng_done = eng_done_r;
  assign bus.eng_z    = eng_z_r;

  always @(posedge clk) begin
    if (bus.eng_start) begin
      eng_res <= modexp(bus.eng_y, bus.eng_x);
      eng_cnt <= L;
      if (hold_h == 0) begin
        eng_done_r <= 1'b0;
        eng_hc     <= 0;
      end else begin
        eng_hc <= hold_h;
      end
    end else if (eng_hc > 0) begin
      eng_hc <= eng_hc - 1;
      if (eng_hc == 1) eng_done_r <= 1'b0;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_done_r <= 1'b1;
        eng_z_r    <= eng_res;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int           start_cnt = 0;
  logic         prev_start = 1'b0;
  logic [K-1:0] last_x = '0;
  logic [K-1:0] last_y = '0;

  always @(negedge clk) begin : mon
    exp_t         e;
    logic [K-1:0] op;
    int           c;
    if (rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (bus.req_valid[ch] && bus.req_ready[ch]) begin
          op     = (ch == 1) ? bus.req_data1 : bus.req_data0;
          e.ch   = ch[0];
          e.err  = (int'(op) >= N);
          e.data = e.err ? '0 : modexp(op, (ch == 1) ? K'(D) : K'(E));
          sb.push_back(e);
        end
      end
      if (bus.rsp_valid != 2'b00) begin
        check("rsp_valid_onehot", (bus.rsp_valid != 2'b11), 1);
        c = bus.rsp_valid[1] ? 1 : 0;
        if (bus.rsp_ready[c]) begin
          if (sb.size() == 0) begin
            check("sb_underflow", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("rsp_ch", c, e.ch);
            check("rsp_err", bus.rsp_err, e.err);
            check("rsp_data", bus.rsp_data, e.data);
          end
        end
      end
      if (bus.eng_start) begin
        start_cnt++;
        last_x = bus.eng_x;
        last_y = bus.eng_y;
        check("start_single_pulse", prev_start, 0);
      end
      prev_start = bus.eng_start;
    end
  end

  // ---------------- stimulus helpers ----------------
  // All helpers start and end #1 after a rising edge.
  task automatic send(input int ch, input logic [K-1:0] op);
    bit ok = 1'b0;
    if (ch == 1) bus.req_data1 = op; else bus.req_data0 = op;
    bus.req_valid[ch] = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req_ready[ch];
    end
    check($sformatf("accept_ch%0d", ch), ok, 1);
    @(posedge clk); #1;
    bus.req_valid[ch] = 1'b0;
  endtask

  task automatic recv(input int ch, input int hold);
    bit           ok = 1'b0;
    logic [1:0]   expv;
    logic [K-1:0] d0;
    logic         e0;
    expv = (ch == 1) ? 2'b10 : 2'b01;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.rsp_valid[ch];
    end
    check($sformatf("rsp_arrive_ch%0d", ch), ok, 1);
    if (hold > 0) begin
      d0 = bus.rsp_data;
      e0 = bus.rsp_err;
      @(posedge clk); #1;
      bus.rsp_ready = ~expv;   // other channel's ready must be ignored
      repeat (hold) begin
        @(negedge clk);
        check("hold_rsp_valid", bus.rsp_valid, expv);
        check("hold_rsp_data", bus.rsp_data, d0);
        check("hold_rsp_err", bus.rsp_err, e0);
        check("hold_no_grant", bus.req_ready, 0);
      end
    end
    @(posedge clk); #1;
    bus.rsp_ready = expv;
    @(negedge clk);
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    check("rsp_dropped", bus.rsp_valid, 0);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_req_ready"}, bus.req_ready, 0);
    check({pfx, "_rsp_valid"}, bus.rsp_valid, 0);
    check({pfx, "_rsp_data"}, bus.rsp_data, 0);
    check({pfx, "_rsp_err"}, bus.rsp_err, 0);
    check({pfx, "_eng_start"}, bus.eng_start, 0);
    check({pfx, "_eng_x"}, bus.eng_x, 0);
    check({pfx, "_eng_y"}, bus.eng_y, 0);
    check({pfx, "_busy"}, busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   s0;
    bit   ok;
    logic g;
    bus.req_valid = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    bus.rsp_ready = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Channel 0, operand 2: one start with E and 2, result 32 held until ready.
    s0 = start_cnt;
    send(0, 12'd2);
    recv(0, 3);
    check("t1_starts", start_cnt - s0, 1);
    check("t1_eng_x", last_x, E);
    check("t1_eng_y", last_y, 2);

    // Channel 1 with 32 uses D and returns 2; channel 0 with 5 returns 3125.
    send(1, 12'd32);
    recv(1, 0);
    check("t2_eng_x", last_x, D);
    check("t2_eng_y", last_y, 32);
    send(0, 12'd5);
    recv(0, 0);

    // Both held from reset: grants alternate 0,1,0,1.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_data0 = 12'd7;
    bus.req_data1 = 12'd7;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      g  = 1'b0;
      for (int j = 0; j < 200 && !ok; j++) begin
        @(negedge clk);
        ok = |bus.req_ready;
        g  = bus.req_ready[1];
      end
      check($sformatf("t3_grant_seen%0d", i), ok, 1);
      check($sformatf("t3_grant_ch%0d", i), g, i % 2);
      @(posedge clk); #1;
      if (i == 3) bus.req_valid = 2'b00;
      recv(int'(g), 0);
    end

    // Out-of-range operand: error response one cycle after accept, no start.
    s0 = start_cnt;
    send(0, 12'd3551);
    @(negedge clk);
    check("t4_err_valid", bus.rsp_valid, 2'b01);
    check("t4_err_flag", bus.rsp_err, 1);
    check("t4_err_data", bus.rsp_data, 0);
    recv(0, 0);
    check("t4_no_start", start_cnt - s0, 0);
    send(0, 12'd3550);
    recv(0, 0);
    check("t4_boundary_start", start_cnt - s0, 1);

    // done still high from the previous op: completion waits for a new rise.
    // A channel-1 request waits behind the held response.
    hold_h = 4;
    s0 = start_cnt;
    send(0, 12'd9);
    bus.req_data1 = 12'd100;
    bus.req_valid[1] = 1'b1;
    recv(0, 10);
    send(1, 12'd100);
    recv(1, 0);
    check("t5_starts", start_cnt - s0, 2);
    hold_h = 0;

    // Reset while waiting on the engine, then a fresh request.
    send(0, 12'd11);
    repeat (5) @(posedge clk);
    #3;
    check("t6_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset("t6");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    s0 = start_cnt;
    send(1, 12'd32);
    recv(1, 0);
    check("t6_restart", start_cnt - s0, 1);
    check("t6_eng_x", last_x, D);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
